obd_frame_tx: RTL and testbench

Telemetry transmitter that sits downstream of the vehicle physics block. On each send request it snapshots the dashboard/OBD values (speed, RPM, fuel, temperature, odometer, gear, engine state, emergency-stop event) into a fixed 13-byte frame. It then serialises the frame over an 8N1 UART line to the host logger. It is the consumer end of the physics block's output bus.

---
 rtl/obd_frame_tx.sv | 204 ++++++++++++++++++++
 tb/tb_obd_frame_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/obd_frame_tx.sv
// Snapshots OBD telemetry into a 13-byte frame and sends it over an 8N1 UART line.
// Define OBD_CRC8_EN to replace the trailing XOR checksum with a CRC-8 (poly 0x07).
module obd_frame_tx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_tick,
    input  logic        engine_on,
    input  logic [7:0]  speed,
    input  logic [13:0] rpm,
    input  logic [7:0]  fuel,
    input  logic [7:0]  temp,
    input  logic [31:0] odometer_raw,
    input  logic [2:0]  gear_num,
    input  logic        ess_trigger,
    output logic        tx,
    output logic        busy,
    output logic [7:0]  frame_cnt
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        logic [7:0] c;
`ifdef OBD_CRC8_EN
        c = acc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
`else
        c = acc ^ b;
`endif
        return c;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [3:0]       byte_q, byte_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       chk_q, chk_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             pending_q, pending_d;
    logic             sticky_q, sticky_d;

    logic [7:0]  seq_s_q, speed_s_q, fuel_s_q, temp_s_q;
    logic [13:0] rpm_s_q;
    logic [31:0] odo_s_q;
    logic [2:0]  gear_s_q;
    logic        eng_s_q, ess_s_q;

    logic       wrap;
    logic       snap;
    logic [3:0] nxt_idx;
    logic [7:0] load_byte;

    assign wrap = (cnt_q == CNT_MAX);

    always_comb begin
        nxt_idx = byte_q + 4'd1;
        case (nxt_idx)
            4'd1:    load_byte = seq_s_q;
            4'd2:    load_byte = speed_s_q;
            4'd3:    load_byte = {2'b00, rpm_s_q[13:8]};
            4'd4:    load_byte = rpm_s_q[7:0];
            4'd5:    load_byte = fuel_s_q;
            4'd6:    load_byte = temp_s_q;
            4'd7:    load_byte = odo_s_q[31:24];
            4'd8:    load_byte = odo_s_q[23:16];
            4'd9:    load_byte = odo_s_q[15:8];
            4'd10:   load_byte = odo_s_q[7:0];
            4'd11:   load_byte = {eng_s_q, ess_s_q, gear_s_q, 3'b000};
            default: load_byte = chk_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        shift_d     = shift_q;
        chk_d       = chk_q;
        frame_cnt_d = frame_cnt_q;
        pending_d   = pending_q;
        sticky_d    = sticky_q | ess_trigger;
        snap        = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            if (send_tick) pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (send_tick) snap = 1'b1;
            end
            ST_START: begin
                if (wrap) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (wrap) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (wrap) begin
                    if (byte_q != 4'd12) begin
                        byte_d  = nxt_idx;
                        shift_d = load_byte;
                        if (nxt_idx != 4'd12) chk_d = chk_update(chk_q, load_byte);
                        state_d = ST_START;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        // A tick landing on the final edge is treated like a pending request.
                        if (pending_q || send_tick) begin
                            snap = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            byte_d  = 4'd0;
                        end
                        pending_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (snap) begin
            state_d  = ST_START;
            cnt_d    = '0;
            bit_d    = 3'd0;
            byte_d   = 4'd0;
            shift_d  = 8'hA5;
            chk_d    = 8'h00;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            byte_q      <= 4'd0;
            chk_q       <= 8'h00;
            frame_cnt_q <= 8'h00;
            pending_q   <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            chk_q       <= chk_d;
            frame_cnt_q <= frame_cnt_d;
            pending_q   <= pending_d;
            sticky_q    <= sticky_d;
        end
    end

    // Frame payload holds no reset; it is always reloaded before use.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (snap) begin
            seq_s_q   <= frame_cnt_d;
            speed_s_q <= speed;
            rpm_s_q   <= rpm;
            fuel_s_q  <= fuel;
            temp_s_q  <= temp;
            odo_s_q   <= odometer_raw;
            gear_s_q  <= gear_num;
            eng_s_q   <= engine_on;
            ess_s_q   <= sticky_q | ess_trigger;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shift_q[0];
            default:  tx = 1'b1;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_obd_frame_tx.sv
// Scoreboard bench for obd_frame_tx: stimulus queues expected bytes, a UART monitor pops and compares.
module tb_obd_frame_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        send_tick = 1'b0;
    logic        engine_on = 1'b0;
    logic [7:0]  speed = '0;
    logic [13:0] rpm = '0;
    logic [7:0]  fuel = '0;
    logic [7:0]  temp = '0;
    logic [31:0] odometer_raw = '0;
    logic [2:0]  gear_num = '0;
    logic        ess_trigger = 1'b0;
    logic        tx;
    logic        busy;
    logic [7:0]  frame_cnt;

    always #5 clk = ~clk;

    obd_frame_tx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
        .clk(clk), .rst(rst), .send_tick(send_tick), .engine_on(engine_on),
        .speed(speed), .rpm(rpm), .fuel(fuel), .temp(temp),
        .odometer_raw(odometer_raw), .gear_num(gear_num), .ess_trigger(ess_trigger),
        .tx(tx), .busy(busy), .frame_cnt(frame_cnt)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model_chk(input logic [7:0] acc, input logic [7:0] b);
        logic [7:0] c;
        c = acc ^ b;
`ifdef OBD_CRC8_EN
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
`endif
        return c;
    endfunction

    task automatic push_frame(input logic [7:0] seq, input logic [7:0] spd, input logic [13:0] r,
                              input logic [7:0] f, input logic [7:0] t, input logic [31:0] odo,
                              input logic [2:0] g, input logic eng, input logic ess);
        logic [7:0] b [13];
        b[0] = 8'hA5; b[1] = seq; b[2] = spd; b[3] = {2'b00, r[13:8]}; b[4] = r[7:0];
        b[5] = f; b[6] = t; b[7] = odo[31:24]; b[8] = odo[23:16]; b[9] = odo[15:8];
        b[10] = odo[7:0]; b[11] = {eng, ess, g, 3'b000}; b[12] = 8'h00;
        for (int i = 1; i <= 11; i++) b[12] = model_chk(b[12], b[i]);
        for (int i = 0; i < 13; i++) exp_q.push_back(b[i]);
    endtask

    // UART receiver: mid-bit sampling on the falling clock edge.
    int         rx_cnt = 0;
    int         rx_num = 0;
    logic       rx_act = 1'b0;
    logic [7:0] rx_byte = '0;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            rx_act = 1'b0;
            rx_cnt = 0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == 5) begin
                if (tx !== 1'b0) rx_act = 1'b0;
            end else if (rx_cnt >= 15 && rx_cnt <= 85 && (rx_cnt % 10) == 5) begin
                rx_byte[(rx_cnt - 15) / 10] = tx;
            end else if (rx_cnt == 95) begin
                rx_act = 1'b0;
                chk("stop_bit", {31'd0, tx}, 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=0x%0h required=none", rx_byte);
                end else begin
                    chk($sformatf("rx_byte%0d", rx_num), {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                end
                rx_num++;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic pulse_tick();
        @(posedge clk);
        #1 send_tick = 1'b1;
        @(posedge clk);
        #1 send_tick = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 6000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic set_default_inputs();
        speed = 8'd100; rpm = 14'd3000; fuel = 8'd80; temp = 8'd90;
        odometer_raw = 32'h0001_2345; gear_num = 3'd4; engine_on = 1'b1; ess_trigger = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic saw_low;
        logic [7:0] single_v [13];
        logic [7:0] crc_v [13];

        single_v = '{8'hA5, 8'h00, 8'h64, 8'h0B, 8'hB8, 8'h50, 8'h5A,
                     8'h00, 8'h01, 8'h23, 8'h45, 8'hA0, 8'h1A};
        crc_v    = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80};
`ifdef OBD_CRC8_EN
        crc_v[12] = 8'h89;
`endif

        // Reset state and quiet line
        do_reset();
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        saw_low = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        chk("idle_tx_stays_high", {31'd0, saw_low}, 32'd0);

        // Single frame with hand-computed bytes
        set_default_inputs();
        for (int i = 0; i < 13; i++) exp_q.push_back(single_v[i]);
        pulse_tick();
        chk("single_busy_at_start", {31'd0, busy}, 32'd1);
        chk("single_tx_start_bit", {31'd0, tx}, 32'd0);
        wait_idle(n);
        chk("single_busy_cycles", n, 1300);
        chk("single_frame_cnt", {24'd0, frame_cnt}, 32'd1);
        repeat (20) @(posedge clk);
        chk("single_queue_drained", exp_q.size(), 0);

        // Pending: three ticks during frame 0, input changes after snapshot
        do_reset();
        set_default_inputs();
        push_frame(8'h00, 8'd100, 14'd3000, 8'd80, 8'd90, 32'h0001_2345, 3'd4, 1'b1, 1'b0);
        push_frame(8'h01, 8'd55,  14'd3000, 8'd80, 8'd90, 32'h0001_2345, 3'd4, 1'b1, 1'b0);
        pulse_tick();
        fork
            wait_idle(n);
            begin
                repeat (100) @(posedge clk);
                #1 speed = 8'd55;
                repeat (100) @(posedge clk);
                pulse_tick();
                repeat (200) @(posedge clk);
                pulse_tick();
                repeat (200) @(posedge clk);
                pulse_tick();
            end
        join
        chk("pending_busy_cycles", n, 2600);
        chk("pending_frame_cnt", {24'd0, frame_cnt}, 32'd2);
        repeat (20) @(posedge clk);
        chk("pending_queue_drained", exp_q.size(), 0);

        // ESS sticky: reported once in the next frame only
        do_reset();
        set_default_inputs();
        push_frame(8'h00, 8'd100, 14'd3000, 8'd80, 8'd90, 32'h0001_2345, 3'd4, 1'b1, 1'b0);
        push_frame(8'h01, 8'd100, 14'd3000, 8'd80, 8'd90, 32'h0001_2345, 3'd4, 1'b1, 1'b1);
        push_frame(8'h02, 8'd100, 14'd3000, 8'd80, 8'd90, 32'h0001_2345, 3'd4, 1'b1, 1'b0);
        pulse_tick();
        fork
            wait_idle(n);
            begin
                repeat (300) @(posedge clk);
                #1 ess_trigger = 1'b1;
                @(posedge clk);
                #1 ess_trigger = 1'b0;
                repeat (200) @(posedge clk);
                pulse_tick();
                repeat (1000) @(posedge clk);
                pulse_tick();
            end
        join
        chk("ess_busy_cycles", n, 3900);
        chk("ess_frame_cnt", {24'd0, frame_cnt}, 32'd3);
        repeat (20) @(posedge clk);
        chk("ess_queue_drained", exp_q.size(), 0);

        // Reset during the start bit of byte 5
        do_reset();
        set_default_inputs();
        for (int i = 0; i < 5; i++) exp_q.push_back(single_v[i]);
        pulse_tick();
        repeat (502) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("midreset_tx", {31'd0, tx}, 32'd1);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        chk("midreset_partial_bytes", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 13; i++) exp_q.push_back(single_v[i]);
        pulse_tick();
        wait_idle(n);
        chk("midreset_next_busy_cycles", n, 1300);
        chk("midreset_next_frame_cnt", {24'd0, frame_cnt}, 32'd1);
        repeat (20) @(posedge clk);
        chk("midreset_queue_drained", exp_q.size(), 0);

        // Trailing-byte check with a single status bit set
        do_reset();
        speed = '0; rpm = '0; fuel = '0; temp = '0; odometer_raw = '0;
        gear_num = 3'd0; engine_on = 1'b1; ess_trigger = 1'b0;
        for (int i = 0; i < 13; i++) exp_q.push_back(crc_v[i]);
        pulse_tick();
        wait_idle(n);
        chk("check_busy_cycles", n, 1300);
        repeat (20) @(posedge clk);
        chk("check_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
